// File: rtl/pec_operand_fetch_if.sv
// rtl/pec_operand_fetch_if.sv - job, buffer-read and partial-sum signals of the operand fetch stage
interface pec_operand_fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int OPD_WIDTH  = 8,
  parameter int ACC_WIDTH  = 24
);
  logic                        PECMAC_Sta;
  logic [DATA_WIDTH-1:0]       PECMAC_FlgAct;
  logic [DATA_WIDTH-1:0]       PECMAC_FlgWei;
  logic [ADDR_WIDTH-1:0]       OffsetAct;
  logic [ADDR_WIDTH-1:0]       OffsetWei;
  logic                        RdEn;
  logic [ADDR_WIDTH-1:0]       ActRdAddr;
  logic [ADDR_WIDTH-1:0]       WeiRdAddr;
  logic signed [OPD_WIDTH-1:0] ActRdDat;
  logic signed [OPD_WIDTH-1:0] WeiRdDat;
  logic                        Busy;
  logic signed [ACC_WIDTH-1:0] Psum;
  logic                        PsumVld;
  logic                        PsumRdy;

  modport slave (
    input  PECMAC_Sta, PECMAC_FlgAct, PECMAC_FlgWei, OffsetAct, OffsetWei,
    input  ActRdDat, WeiRdDat, PsumRdy,
    output RdEn, ActRdAddr, WeiRdAddr, Busy, Psum, PsumVld
  );

  modport master (
    output PECMAC_Sta, PECMAC_FlgAct, PECMAC_FlgWei, OffsetAct, OffsetWei,
    output ActRdDat, WeiRdDat, PsumRdy,
    input  RdEn, ActRdAddr, WeiRdAddr, Busy, Psum, PsumVld
  );
endinterface

// File: rtl/pec_operand_fetch.sv
// rtl/pec_operand_fetch.sv - issues matched-pair buffer reads, multiplies operands, accumulates a partial sum
// OFFSET_LAT counts the start cycle itself, so it must be at least 2.
module pec_operand_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int OPD_WIDTH  = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int OFFSET_LAT = 2
) (
  input logic                clk,
  input logic                rst,
  pec_operand_fetch_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(OFFSET_LAT - 2);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [CNT_W-1:0]              n_q;
  logic [CNT_W-1:0]              match_cnt;
  logic                          accept;
  logic                          rd_en;
  logic                          rd_vld_q;
  logic                          prod_vld_q;
  logic signed [2*OPD_WIDTH-1:0] prod_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;

  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      match_cnt = match_cnt + CNT_W'(bus.PECMAC_FlgAct[i] & bus.PECMAC_FlgWei[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) n_q <= match_cnt;
    end
  end

  // cnt is reused per state: wait cycles, pairs issued, drain cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.PECMAC_Sta) begin
          accept  = 1'b1;
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = (n_q != '0) ? S_ISSUE : S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ISSUE: begin
        rd_en = 1'b1;
        if (cnt_q == n_q - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.PsumRdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-stage pipe: operands arrive the cycle after RdEn, product is added one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
    end else begin
      rd_vld_q   <= rd_en;
      prod_vld_q <= rd_vld_q;
      if (rd_vld_q) prod_q <= bus.ActRdDat * bus.WeiRdDat;
      if (accept) begin
        acc_q <= '0;
      end else if (prod_vld_q) begin
        acc_q <= acc_q + ACC_WIDTH'(prod_q);
      end
    end
  end

  assign bus.RdEn      = rd_en;
  assign bus.ActRdAddr = rd_en ? bus.OffsetAct : '0;
  assign bus.WeiRdAddr = rd_en ? bus.OffsetWei : '0;
  assign bus.Busy      = (state_q != S_IDLE);
  assign bus.PsumVld   = (state_q == S_DONE);
  assign bus.Psum      = (state_q == S_DONE) ? acc_q : '0;
endmodule

// File: tb/tb_pec_operand_fetch.sv
// tb/tb_pec_operand_fetch.sv - scoreboard bench for pec_operand_fetch, 24-bit and 16-bit accumulator instances
module tb_pec_operand_fetch;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pec_operand_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPD_WIDTH(OW), .ACC_WIDTH(24)) b24 ();
  pec_operand_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPD_WIDTH(OW), .ACC_WIDTH(16)) b16 ();

  pec_operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPD_WIDTH(OW), .ACC_WIDTH(24), .OFFSET_LAT(2))
    dut24 (.clk(clk), .rst(rst), .bus(b24));
  pec_operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPD_WIDTH(OW), .ACC_WIDTH(16), .OFFSET_LAT(2))
    dut16 (.clk(clk), .rst(rst), .bus(b16));

  assign b16.PECMAC_Sta    = b24.PECMAC_Sta;
  assign b16.PECMAC_FlgAct = b24.PECMAC_FlgAct;
  assign b16.PECMAC_FlgWei = b24.PECMAC_FlgWei;
  assign b16.OffsetAct     = b24.OffsetAct;
  assign b16.OffsetWei     = b24.OffsetWei;
  assign b16.ActRdDat      = b24.ActRdDat;
  assign b16.WeiRdDat      = b24.WeiRdDat;
  assign b16.PsumRdy       = b24.PsumRdy;

  int errors = 0;
  int checks = 0;
  longint exp24_q[$];
  longint exp16_q[$];
  int act_v[DW];
  int wei_v[DW];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain dot product over channels where both flags are set, wrapped to each width.
  task automatic push_expected(input logic [DW-1:0] fa, input logic [DW-1:0] fw);
    int sum;
    logic signed [23:0] w24;
    logic signed [15:0] w16;
    sum = 0;
    for (int i = 0; i < DW; i++) if (fa[i] && fw[i]) sum += act_v[i] * wei_v[i];
    w24 = sum[23:0];
    w16 = sum[15:0];
    exp24_q.push_back(longint'(w24));
    exp16_q.push_back(longint'(w16));
  endtask

  bit held = 1'b0;
  logic signed [23:0] held_p;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_vld", b24.PsumVld, 1);
        chk("hold_psum", b24.Psum, held_p);
      end
      held = 1'b0;
      if (b24.PsumVld) begin
        if (b24.PsumRdy) begin
          if (exp24_q.size() == 0) begin
            chk("unexpected_psum", 1, 0);
          end else begin
            chk("psum24", b24.Psum, exp24_q.pop_front());
            chk("vld16", b16.PsumVld, 1);
            chk("psum16", b16.Psum, exp16_q.pop_front());
          end
        end else begin
          held   = 1'b1;
          held_p = b24.Psum;
        end
      end
    end
  end

  task automatic drive_idle();
    b24.PECMAC_Sta    = 1'b0;
    b24.PECMAC_FlgAct = '0;
    b24.PECMAC_FlgWei = '0;
    b24.OffsetAct     = '0;
    b24.OffsetWei     = '0;
    b24.ActRdDat      = '0;
    b24.WeiRdDat      = '0;
    b24.PsumRdy       = 1'b0;
  endtask

  // Called at posedge+1. abort_at>=0 resets the DUT after that many reads; hold_rdy stalls DONE.
  task automatic run_job(input logic [DW-1:0] fa, input logic [DW-1:0] fw, input int abort_at, input bit hold_rdy);
    int act_mem[DW];
    int wei_mem[DW];
    int ea[$];
    int ew[$];
    int n, ka, kw, guard, stall;
    bit last_rd, accepted, in_issue;
    logic [AW-1:0] last_a, last_w;
    ka = 0; kw = 0;
    for (int i = 0; i < DW; i++) begin
      act_mem[i] = 0; wei_mem[i] = 0;
    end
    for (int i = 0; i < DW; i++) begin
      if (fa[i] && fw[i]) begin
        ea.push_back(ka);
        ew.push_back(kw);
      end
      if (fa[i]) begin act_mem[ka] = act_v[i]; ka++; end
      if (fw[i]) begin wei_mem[kw] = wei_v[i]; kw++; end
    end
    n = ea.size();
    guard = 0;
    while (b24.Busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", 0, 1);
    b24.PECMAC_Sta    = 1'b1;
    b24.PECMAC_FlgAct = fa;
    b24.PECMAC_FlgWei = fw;
    b24.PsumRdy       = 1'($urandom);
    if (abort_at < 0) push_expected(fa, fw);
    @(posedge clk); #1;
    b24.PECMAC_Sta = 1'b0;
    last_rd = 1'b0; last_a = '0; last_w = '0;
    accepted = 1'b0;
    for (int c = 1; c <= n + 4; c++) begin
      in_issue = (c >= 2 && c <= n + 1);
      b24.OffsetAct = in_issue ? AW'(ea[c-2]) : AW'($urandom);
      b24.OffsetWei = in_issue ? AW'(ew[c-2]) : AW'($urandom);
      b24.ActRdDat  = last_rd ? OW'(act_mem[last_a]) : OW'($urandom);
      b24.WeiRdDat  = last_rd ? OW'(wei_mem[last_w]) : OW'($urandom);
      b24.PsumRdy   = hold_rdy ? 1'b0 : 1'($urandom);
      @(negedge clk);
      chk("rden", b24.RdEn, in_issue);
      chk("act_addr", b24.ActRdAddr, in_issue ? ea[c-2] : 0);
      chk("wei_addr", b24.WeiRdAddr, in_issue ? ew[c-2] : 0);
      chk("busy", b24.Busy, 1);
      chk("psum_vld_time", b24.PsumVld, c == n + 4);
      last_rd = b24.RdEn; last_a = b24.ActRdAddr; last_w = b24.WeiRdAddr;
      accepted = b24.PsumVld && b24.PsumRdy;
      if (abort_at >= 0 && c == abort_at + 1) begin
        @(posedge clk); #1;
        rst = 1'b1;
        b24.PsumRdy = 1'b0;
        #1;
        chk("abort_rden", b24.RdEn, 0);
        chk("abort_busy", b24.Busy, 0);
        chk("abort_vld", b24.PsumVld, 0);
        chk("abort_psum", b24.Psum, 0);
        chk("abort_addr", b24.ActRdAddr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    stall = 0;
    while (!accepted && stall < 200) begin
      b24.PsumRdy    = hold_rdy ? (stall >= 5) : 1'($urandom);
      b24.PECMAC_Sta = hold_rdy && (stall == 2);
      @(negedge clk);
      chk("done_busy", b24.Busy, 1);
      chk("done_vld", b24.PsumVld, 1);
      accepted = b24.PsumRdy;
      stall++;
      @(posedge clk); #1;
    end
    if (!accepted) chk("handshake_timeout", 0, 1);
    b24.PECMAC_Sta = 1'b0;
    b24.PsumRdy    = 1'b0;
    chk("idle_after_hs", b24.Busy, 0);
  endtask

  task automatic fill(input int a, input int w);
    for (int i = 0; i < DW; i++) begin
      act_v[i] = a; wei_v[i] = w;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DW; i++) begin
      act_v[i] = int'($urandom_range(0, 255)) - 128;
      wei_v[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  initial begin
    logic [DW-1:0] fa, fw;
    int guard;
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rden", b24.RdEn, 0);
    chk("rst_busy", b24.Busy, 0);
    chk("rst_vld", b24.PsumVld, 0);
    chk("rst_psum", b24.Psum, 0);
    chk("rst_addr", b24.WeiRdAddr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    fill(1, 2);
    run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    fill_random();
    run_job(32'h0000_000F, 32'h0000_00F0, -1, 1'b0);
    fill(-128, -128);
    run_job(32'h0000_0007, 32'h0000_0007, -1, 1'b0);
    fill(-128, 127);
    run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    fill_random();
    run_job(32'h0F0F_1234, 32'h00FF_5678, -1, 1'b1);
    fill_random();
    run_job(32'h0000_03FF, 32'h0000_03FF, 4, 1'b0);
    fill_random();
    run_job(32'h0000_03FF, 32'h0000_03FF, -1, 1'b0);

    for (int j = 0; j < 1000; j++) begin
      fill_random();
      case ($urandom_range(0, 3))
        0: begin fa = $urandom; fw = $urandom; end
        1: begin fa = $urandom & $urandom; fw = $urandom | $urandom; end
        2: begin fa = $urandom | $urandom; fw = $urandom | $urandom; end
        default: begin fa = $urandom & $urandom & $urandom; fw = $urandom & $urandom; end
      endcase
      run_job(fa, fw, -1, ($urandom_range(0, 19) == 0));
    end

    guard = 0;
    while (exp24_q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("scoreboard_drained", exp24_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
